// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl
// Multicycle control FSM for the LEGv8 datapath. It sequences one shared
// memory port, the ALU, the register file and the immediate sign-extender.
// Instruction flow: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH.
// An undecodable instruction parks the FSM in ERR until reset.
//
// Optional build macro CTRL_PERFCNT_EN adds the cycle_cnt and instr_cnt
// performance counters. Without it, those ports and registers do not exist.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   run               permits a new fetch; sampled only in FETCH
//   instr             instruction register contents, stable from DECODE on
//   alu_zero          ALU zero flag, used by CBZ in EXEC
//   mem_ready         memory completes the pending request this cycle
//   mem_req/mem_we    memory request and write strobe
//   iord              0 = PC address, 1 = ALU address
//   ir_write          IR load; pc_write/pc_src drive the PC update
//   reg_write         register file write; mem_to_reg selects memory data
//   alu_src_b         0 = register, 1 = sign-extended immediate
//   ext_sel           immediate format: 00 I, 01 D, 10 B, 11 CB
//   alu_op            0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B
//   illegal           sticky undecodable-instruction flag (ERR state)
//   busy              high except in idle FETCH and in ERR
//   cycle_cnt         (CTRL_PERFCNT_EN) counts cycles with busy=1
//   instr_cnt         (CTRL_PERFCNT_EN) counts completed instructions
module legv8_multicycle_ctrl #(
   parameter int ALU_OP_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic [31:0]         instr,
   input  logic                alu_zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                iord,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_src,
   output logic                reg_write,
   output logic                mem_to_reg,
   output logic                alu_src_b,
   output logic [1:0]          ext_sel,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                illegal,
   output logic                busy
`ifdef CTRL_PERFCNT_EN
   ,
   output logic [31:0]         cycle_cnt,
   output logic [31:0]         instr_cnt
`endif
);

   localparam logic [ALU_OP_W-1:0] OP_AND   = ALU_OP_W'(4'b0000);
   localparam logic [ALU_OP_W-1:0] OP_ORR   = ALU_OP_W'(4'b0001);
   localparam logic [ALU_OP_W-1:0] OP_ADD   = ALU_OP_W'(4'b0010);
   localparam logic [ALU_OP_W-1:0] OP_SUB   = ALU_OP_W'(4'b0110);
   localparam logic [ALU_OP_W-1:0] OP_PASSB = ALU_OP_W'(4'b0111);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
   } state_t;

   typedef enum logic [2:0] {
      CLS_R, CLS_I, CLS_D, CLS_CB, CLS_B, CLS_BAD
   } cls_t;

   typedef struct packed {
      cls_t                cls;
      logic [ALU_OP_W-1:0] op;
      logic                store;
   } dec_t;

   state_t              state, state_n;
   cls_t                cls_q;
   logic [ALU_OP_W-1:0] op_q;
   logic                store_q;
   logic                fetch_act, fetch_act_n;
   logic                fetch_on;
   dec_t                dec;

   // Operand fields are consumed by the datapath, not by this controller.
   logic unused_fields;
   assign unused_fields = ^instr[20:0];

   function automatic dec_t decode(input logic [31:0] ir);
      dec_t d;
      d.cls   = CLS_BAD;
      d.op    = OP_ADD;
      d.store = 1'b0;
      if (ir[31:26] == 6'b000101) begin
         d.cls = CLS_B;
      end else if (ir[31:24] == 8'b10110100) begin
         d.cls = CLS_CB;
         d.op  = OP_PASSB;
      end else begin
         case (ir[31:21])
            11'b10001011000: begin d.cls = CLS_R; d.op = OP_ADD; end
            11'b11001011000: begin d.cls = CLS_R; d.op = OP_SUB; end
            11'b10001010000: begin d.cls = CLS_R; d.op = OP_AND; end
            11'b10101010000: begin d.cls = CLS_R; d.op = OP_ORR; end
            11'b11111000010: begin d.cls = CLS_D; end
            11'b11111000000: begin d.cls = CLS_D; d.store = 1'b1; end
            default: begin
               case (ir[31:22])
                  10'b1001000100: begin d.cls = CLS_I; d.op = OP_ADD; end
                  10'b1001001000: begin d.cls = CLS_I; d.op = OP_AND; end
                  10'b1011001000: begin d.cls = CLS_I; d.op = OP_ORR; end
                  10'b1101000100: begin d.cls = CLS_I; d.op = OP_SUB; end
                  default:        d.cls = CLS_BAD;
               endcase
            end
         endcase
      end
      return d;
   endfunction

   assign dec = decode(instr);

   // Once a fetch request is raised it must stay up until mem_ready, even
   // if run drops while the memory is stalling.
   assign fetch_on = (state == S_FETCH) && (run || fetch_act);

   always_comb begin
      state_n     = state;
      fetch_act_n = 1'b0;
      case (state)
         S_FETCH: begin
            if (fetch_on) begin
               if (mem_ready) state_n = S_DECODE;
               else           fetch_act_n = 1'b1;
            end
         end
         S_DECODE: state_n = (dec.cls == CLS_BAD) ? S_ERR : S_EXEC;
         S_EXEC: begin
            case (cls_q)
               CLS_R, CLS_I:  state_n = S_WB;
               CLS_D:         state_n = S_MEM;
               CLS_CB, CLS_B: state_n = S_FETCH;
               default:       state_n = S_ERR;
            endcase
         end
         S_MEM:   if (mem_ready) state_n = store_q ? S_FETCH : S_WB;
         S_WB:    state_n = S_FETCH;
         S_ERR:   state_n = S_ERR;
         default: state_n = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_FETCH;
         fetch_act <= 1'b0;
         cls_q     <= CLS_BAD;
         op_q      <= OP_ADD;
         store_q   <= 1'b0;
      end else begin
         state     <= state_n;
         fetch_act <= fetch_act_n;
         if (state == S_DECODE) begin
            cls_q   <= dec.cls;
            op_q    <= dec.op;
            store_q <= dec.store;
         end
      end
   end

   // Outputs decode from the registered state and latched class. The only
   // input-dependent terms are the fetch qualifiers (run, mem_ready) and the
   // CBZ branch decision (alu_zero). rst forces everything low at once, so a
   // request in flight is dropped in the same cycle.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_b  = 1'b0;
      ext_sel    = 2'b00;
      alu_op     = OP_AND;
      illegal    = 1'b0;
      busy       = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               if (fetch_on) begin
                  busy    = 1'b1;
                  mem_req = 1'b1;
                  if (mem_ready) begin
                     ir_write = 1'b1;
                     pc_write = 1'b1;
                  end
               end
            end
            S_DECODE: busy = 1'b1;
            S_EXEC: begin
               busy = 1'b1;
               case (cls_q)
                  CLS_R: alu_op = op_q;
                  CLS_I: begin
                     alu_op    = op_q;
                     alu_src_b = 1'b1;
                  end
                  CLS_D: begin
                     alu_op    = OP_ADD;
                     alu_src_b = 1'b1;
                     ext_sel   = 2'b01;
                  end
                  CLS_CB: begin
                     alu_op   = OP_PASSB;
                     ext_sel  = 2'b11;
                     pc_write = alu_zero;
                     pc_src   = alu_zero;
                  end
                  CLS_B: begin
                     ext_sel  = 2'b10;
                     pc_write = 1'b1;
                     pc_src   = 1'b1;
                  end
                  default: busy = 1'b1;
               endcase
            end
            S_MEM: begin
               // ALU controls held so the address stays stable while waiting.
               busy      = 1'b1;
               mem_req   = 1'b1;
               iord      = 1'b1;
               mem_we    = store_q;
               alu_op    = OP_ADD;
               alu_src_b = 1'b1;
               ext_sel   = 2'b01;
            end
            S_WB: begin
               busy       = 1'b1;
               reg_write  = 1'b1;
               mem_to_reg = (cls_q == CLS_D);
               // R/I results are written straight from the ALU, so keep it set.
               if (cls_q == CLS_R || cls_q == CLS_I) begin
                  alu_op    = op_q;
                  alu_src_b = (cls_q == CLS_I);
               end
            end
            S_ERR:   illegal = 1'b1;
            default: busy = 1'b0;
         endcase
      end
   end

`ifdef CTRL_PERFCNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= 32'd0;
         instr_cnt <= 32'd0;
      end else begin
         if (busy) cycle_cnt <= cycle_cnt + 32'd1;
         if ((state == S_EXEC || state == S_MEM || state == S_WB) && state_n == S_FETCH)
            instr_cnt <= instr_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed testbench for legv8_multicycle_ctrl. Inputs are driven just after
// the falling edge and outputs are checked 1 time unit later, well away from
// the rising (active) edge.
module tb_legv8_multicycle_ctrl;
   localparam int ALU_OP_W = 4;

   logic                clk = 1'b0;
   logic                rst, run, alu_zero, mem_ready;
   logic [31:0]         instr;
   logic                mem_req, mem_we, iord, ir_write, pc_write, pc_src;
   logic                reg_write, mem_to_reg, alu_src_b, illegal, busy;
   logic [1:0]          ext_sel;
   logic [ALU_OP_W-1:0] alu_op;
`ifdef CTRL_PERFCNT_EN
   logic [31:0]         cycle_cnt, instr_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   legv8_multicycle_ctrl #(.ALU_OP_W(ALU_OP_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .instr      (instr),
      .alu_zero   (alu_zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .iord       (iord),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .reg_write  (reg_write),
      .mem_to_reg (mem_to_reg),
      .alu_src_b  (alu_src_b),
      .ext_sel    (ext_sel),
      .alu_op     (alu_op),
      .illegal    (illegal),
      .busy       (busy)
`ifdef CTRL_PERFCNT_EN
      ,
      .cycle_cnt  (cycle_cnt),
      .instr_cnt  (instr_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nc();
      @(negedge clk);
   endtask

   // Called in the cycle a fetch is accepted; counts that cycle plus every
   // following busy cycle until the FSM is back in idle FETCH.
   task automatic drain(input string tag, input int exp);
      int  n    = 1;
      bit  done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         nc();
         run = 1'b0;
         #1;
         if (!busy) done = 1'b1;
         else       n++;
      end
      if (!done) n = -1;
      chk(tag, n, exp);
   endtask

   // Zero-wait instruction from idle FETCH, checking the fetch strobes.
   task automatic exec_instr(input string tag, input logic [31:0] iv, input int lat);
      instr     = iv;
      run       = 1'b1;
      mem_ready = 1'b1;
      #1;
      chk({tag, "_irw"}, ir_write, 1'b1);
      drain({tag, "_lat"}, lat);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; run = 1'b1; alu_zero = 1'b0; mem_ready = 1'b1; instr = 32'h0;
      #1;
      // Reset: everything low even with run and mem_ready high.
      chk("rst_req",  mem_req, 1'b0);
      chk("rst_busy", busy,    1'b0);
      chk("rst_irw",  ir_write, 1'b0);
      chk("rst_ill",  illegal, 1'b0);
      run = 1'b0;
      nc(); nc();
      rst = 1'b0;
      #1;
      chk("idle_busy", busy, 1'b0);

      // ADDI X1,X0,#2
      instr = 32'h91000801; run = 1'b1; mem_ready = 1'b1;
      #1;
      chk("addi_f_req",   mem_req,  1'b1);
      chk("addi_f_iord",  iord,     1'b0);
      chk("addi_f_irw",   ir_write, 1'b1);
      chk("addi_f_pcw",   pc_write, 1'b1);
      chk("addi_f_pcsrc", pc_src,   1'b0);
      nc(); run = 1'b0; #1;
      chk("addi_d_busy", busy,    1'b1);
      chk("addi_d_req",  mem_req, 1'b0);
      nc(); #1;
      chk("addi_e_op",   alu_op,    4'b0010);
      chk("addi_e_srcb", alu_src_b, 1'b1);
      chk("addi_e_ext",  ext_sel,   2'b00);
      chk("addi_e_rw",   reg_write, 1'b0);
      nc(); #1;
      chk("addi_wb_rw",  reg_write,  1'b1);
      chk("addi_wb_m2r", mem_to_reg, 1'b0);
      nc(); #1;
      chk("addi_back_busy", busy,    1'b0);
      chk("addi_back_req",  mem_req, 1'b0);

      // B immediately after, then the counters (if built in).
      exec_instr("b", 32'h14000002, 3);
`ifdef CTRL_PERFCNT_EN
      chk("perf_instr", instr_cnt, 32'd2);
      chk("perf_cycle", cycle_cnt, 32'd7);
`endif

      // mem_ready ignored while idle.
      mem_ready = 1'b1; run = 1'b0; #1;
      chk("ign_irw", ir_write, 1'b0);
      chk("ign_pcw", pc_write, 1'b0);
      nc(); #1;
      chk("ign_busy", busy, 1'b0);

      // SUB with one fetch wait state; run drops while waiting.
      instr = 32'hCB020020; run = 1'b1; mem_ready = 1'b0; #1;
      chk("fw_req1", mem_req,  1'b1);
      chk("fw_irw1", ir_write, 1'b0);
      nc(); run = 1'b0; #1;
      chk("fw_req2", mem_req, 1'b1);
      chk("fw_iord", iord,    1'b0);
      nc(); mem_ready = 1'b1; #1;
      chk("fw_irw3", ir_write, 1'b1);
      nc(); #1;
      nc(); #1;
      chk("sub_e_op",   alu_op,    4'b0110);
      chk("sub_e_srcb", alu_src_b, 1'b0);
      drain("sub_tail", 2);

      // LDUR X2,[X0,#8] with two memory wait states.
      instr = 32'hF8408002; run = 1'b1; mem_ready = 1'b1; #1;
      nc(); run = 1'b0;
      nc(); #1;
      chk("ldur_e_op",   alu_op,    4'b0010);
      chk("ldur_e_srcb", alu_src_b, 1'b1);
      chk("ldur_e_ext",  ext_sel,   2'b01);
      for (int w = 0; w < 3; w++) begin
         nc(); mem_ready = (w == 2); #1;
         chk("ldur_m_req",  mem_req, 1'b1);
         chk("ldur_m_iord", iord,    1'b1);
         chk("ldur_m_we",   mem_we,  1'b0);
      end
      nc(); #1;
      chk("ldur_wb_rw",  reg_write,  1'b1);
      chk("ldur_wb_m2r", mem_to_reg, 1'b1);
      nc(); #1;
      chk("ldur_back", busy, 1'b0);

      // Zero-wait latencies of the remaining classes.
      exec_instr("stur", 32'hF8008001, 4);
      exec_instr("orri", 32'hB2000421, 4);
      exec_instr("and",  32'h8A020020, 4);
      exec_instr("ldur", 32'hF8408002, 5);

      // CBZ taken and not taken.
      for (int z = 1; z >= 0; z--) begin
         alu_zero = z[0];
         instr = 32'hB4000083; run = 1'b1; mem_ready = 1'b1; #1;
         nc(); run = 1'b0;
         nc(); #1;
         chk("cbz_pcw",   pc_write, z[0]);
         chk("cbz_pcsrc", pc_src,   z[0]);
         chk("cbz_ext",   ext_sel,  2'b11);
         chk("cbz_op",    alu_op,   4'b0111);
         nc(); #1;
         chk("cbz_back", busy, 1'b0);
      end
      alu_zero = 1'b0;

      // B: unconditional PC update in EXEC.
      instr = 32'h14000002; run = 1'b1; #1;
      nc(); run = 1'b0;
      nc(); #1;
      chk("b_pcw",   pc_write, 1'b1);
      chk("b_pcsrc", pc_src,   1'b1);
      chk("b_ext",   ext_sel,  2'b10);
      nc(); #1;
      chk("b_back", busy, 1'b0);

      // Illegal instruction: sticky, no further requests, cleared by rst.
      instr = 32'h00000000; run = 1'b1; #1;
      nc(); #1;
      chk("ill_d", illegal, 1'b0);
      nc(); #1;
      chk("ill_set",  illegal, 1'b1);
      chk("ill_busy", busy,    1'b0);
      chk("ill_req",  mem_req, 1'b0);
      nc(); #1;
      chk("ill_hold", illegal, 1'b1);
      chk("ill_req2", mem_req, 1'b0);
      rst = 1'b1; #1;
      chk("ill_rst", illegal, 1'b0);
      nc(); rst = 1'b0; instr = 32'h91000801; mem_ready = 1'b0; #1;
      chk("ill_refetch", mem_req, 1'b1);
      mem_ready = 1'b1; #1;
      drain("ill_resume", 4);

      // Reset during a stalled STUR data phase.
      instr = 32'hF8008001; run = 1'b1; mem_ready = 1'b1; #1;
      nc(); run = 1'b0;
      nc();
      nc(); mem_ready = 1'b0; #1;
      chk("stur_m_req", mem_req, 1'b1);
      chk("stur_m_we",  mem_we,  1'b1);
      chk("stur_m_iord", iord,   1'b1);
      #2; rst = 1'b1; #1;
      chk("stur_rst_req", mem_req, 1'b0);
      chk("stur_rst_we",  mem_we,  1'b0);
      nc(); rst = 1'b0; #1;
      chk("stur_rst_idle", busy, 1'b0);
      instr = 32'h91000801; run = 1'b1; #1;
      chk("restart_req",  mem_req, 1'b1);
      chk("restart_iord", iord,    1'b0);
      chk("restart_we",   mem_we,  1'b0);
      mem_ready = 1'b1; #1;
      drain("restart_lat", 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
